araddr_fifo_ar_sched: RTL

- Drains read-burst start addresses from the 32-bit, 2048-deep asynchronous araddr FIFO, read side only.
- Issues each address as one AXI4 AR transaction toward the DDR controller, with a fixed burst length.
- Throttles issue against a bound on outstanding bursts; a burst retires on its R-channel last beat.
- Sits in the rd_clk domain, between the frame-read address generator (write side of the FIFO) and the DDR AXI read port.

---
 rtl/ar_sched_pkg.sv | 24 ++
 rtl/ar_sched_os_cnt.sv | 48 ++++
 rtl/araddr_fifo_ar_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ar_sched_pkg.sv
// ---------------------------------------------------------------------------
// ar_sched_pkg
// Shared definitions for the araddr FIFO AR scheduler:
//   - ar_state_e     : scheduler state encoding (IDLE / POP / LOAD / ISSUE)
//   - AXI_BURST_INCR : AXI4 INCR burst encoding driven on arburst
//   - calc_arlen     : arlen value for a given burst length in beats
// ---------------------------------------------------------------------------
package ar_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ISSUE = 2'd3
    } ar_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // AXI encodes burst length as beats-1; legal lengths are 1..256.
    function automatic logic [7:0] calc_arlen(input int unsigned burst_len);
        return 8'(burst_len - 1);
    endfunction

endpackage

// File: rtl/ar_sched_os_cnt.sv
// ---------------------------------------------------------------------------
// ar_sched_os_cnt
// Outstanding-burst up/down counter. Saturates at 0 on a stray decrement
// and at all-ones on an increment, so the count can never wrap.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   inc      in   one burst accepted (AR handshake)
//   dec      in   one burst retired (R last beat)
//   limit    in   count value at or above which at_limit is raised
//   count    out  current number of unretired bursts
//   at_limit out  count >= limit
// ---------------------------------------------------------------------------
module ar_sched_os_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 at_limit
);

    logic inc_ok;
    logic dec_ok;

    // A retire with nothing outstanding is a protocol error from the far
    // side; ignoring it keeps the count from underflowing.
    assign dec_ok = dec && (count != '0);
    assign inc_ok = inc && (count != '1);

    // NOTE: registered state is always written with non-blocking assignments
    // so every flop samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc_ok && !dec_ok) begin
            count <= count + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            count <= count - 1'b1;
        end
    end

    assign at_limit = (count >= limit);

endmodule

// File: rtl/araddr_fifo_ar_sched.sv
// ---------------------------------------------------------------------------
// araddr_fifo_ar_sched
// Pops read-burst start addresses from the araddr FIFO (read side) and
// issues each one as a single fixed-length AXI4 AR transaction, keeping the
// number of accepted-but-unretired bursts at or below MAX_OUTSTANDING.
// A burst retires on its R-channel last beat.
//
// Optional feature (macro AR_SCHED_PERF_CNT_EN): adds perf_clr input and
// perf_bursts / perf_stall 32-bit counters.
//
// Ports:
//   clk            in   clock (FIFO rd_clk)
//   rst            in   synchronous active-high reset
//   en             in   scheduler enable; gates new pops only
//   fifo_rd_en     out  FIFO read enable, one-cycle pulse per address
//   fifo_rd_data   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_empty  in   FIFO empty flag
//   m_ar*          out  AXI4 AR channel (arid/arlen/arsize/arburst constant)
//   m_arready      in   AXI4 AR ready
//   m_rvalid/m_rready/m_rlast in  R channel, observed only
//   busy           out  state != IDLE or bursts outstanding
//   outstanding    out  current count of unretired bursts
//   perf_clr       in   (macro only) clear both perf counters
//   perf_bursts    out  (macro only) AR handshakes, wraps mod 2^32
//   perf_stall     out  (macro only) cycles with arvalid && !arready
// ---------------------------------------------------------------------------
module araddr_fifo_ar_sched
    import ar_sched_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int ARID_VAL        = 0,
    parameter int BURST_LEN       = 16,
    parameter int SIZE_LOG2       = 5,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [ADDR_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic                  m_rready,
    input  logic                  m_rlast,
    output logic                  busy,
    output logic [7:0]            outstanding
`ifdef AR_SCHED_PERF_CNT_EN
    ,
    input  logic                  perf_clr,
    output logic [31:0]           perf_bursts,
    output logic [31:0]           perf_stall
`endif
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] POP   = ST_POP;
    localparam logic [1:0] LOAD  = ST_LOAD;
    localparam logic [1:0] ISSUE = ST_ISSUE;

    logic [1:0] state;
    logic       ar_hs;
    logic       retire;
    logic       in_flight;
    logic       at_limit;
    logic       pop_ok;
    logic [7:0] limit_eff;

    assign m_arid    = ID_WIDTH'(ARID_VAL);
    assign m_arlen   = calc_arlen(BURST_LEN);
    assign m_arsize  = 3'(SIZE_LOG2);
    assign m_arburst = AXI_BURST_INCR;

    assign ar_hs  = m_arvalid && m_arready;
    assign retire = m_rvalid && m_rready && m_rlast;

    // An address that has been popped but not yet accepted on AR already
    // claims a slot, so the limit seen by the counter shrinks by one.
    assign in_flight = (state != IDLE);
    assign limit_eff = 8'(MAX_OUTSTANDING) - {7'd0, in_flight};
    assign pop_ok    = en && !fifo_rd_empty && !at_limit;

    ar_sched_os_cnt #(
        .CNT_WIDTH (8)
    ) u_os_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (ar_hs),
        .dec      (retire),
        .limit    (limit_eff),
        .count    (outstanding),
        .at_limit (at_limit)
    );

    // Once popped, an address always runs through to its AR handshake;
    // en only gates the next pop from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_ok) begin
                        fifo_rd_en <= 1'b1;
                        state      <= POP;
                    end
                end
                POP: begin
                    fifo_rd_en <= 1'b0;
                    state      <= LOAD;
                end
                LOAD: begin
                    m_araddr  <= fifo_rd_data;
                    m_arvalid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE) || (outstanding != 8'd0);

`ifdef AR_SCHED_PERF_CNT_EN
    // Clear wins over a same-cycle increment; both counters wrap freely.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_bursts <= '0;
            perf_stall  <= '0;
        end else begin
            if (ar_hs) begin
                perf_bursts <= perf_bursts + 32'd1;
            end
            if (m_arvalid && !m_arready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
